// File: rtl/host_seq.sv
// host_seq: host-side job sequencer for the corelet.
//
// One job is: stream W_WORDS weight words into W SRAM, stream ACT_WORDS
// activation words into ACT SRAM, hand the SRAMs to the corelet with a
// seq_begin pulse, wait for seq_done, then drain OP_WORDS 128-bit results
// out of OP SRAM one word at a time through a valid/ready stream.
//
// Optional feature: define HOST_SEQ_TIMEOUT_EN to add a 12-bit RUN watchdog.
// With it, a corelet that never answers sets the sticky err flag after
// 4095 RUN cycles and the job ends without draining. Without it, RUN waits
// indefinitely and err is tied low.

module host_seq #(
    parameter int ACT_WORDS = 36,
    parameter int W_WORDS   = 72,
    parameter int OP_WORDS  = 16
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         start,
    output logic         busy,
    output logic         job_done,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,

    output logic [31:0]  W_d,
    output logic [6:0]   W_addr,
    output logic         W_cen,
    output logic         W_wen,

    output logic [31:0]  ACT_d,
    output logic [6:0]   ACT_addr,
    output logic         ACT_cen,
    output logic         ACT_wen,

    output logic         host_sel,

    output logic         seq_begin,
    input  logic         seq_done,

    input  logic [127:0] OP_q,
    output logic [3:0]   OP_addr,
    output logic         OP_cen,
    output logic         OP_wen,

    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,

    output logic         err
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_W   = 3'd1;
    localparam logic [2:0] S_LOAD_ACT = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_RD_REQ   = 3'd4;
    localparam logic [2:0] S_RD_WAIT  = 3'd5;
    localparam logic [2:0] S_RD_HOLD  = 3'd6;

    // Last index of each transfer, sized to the shared word counter.
    localparam logic [6:0] W_LAST   = 7'(W_WORDS - 1);
    localparam logic [6:0] ACT_LAST = 7'(ACT_WORDS - 1);
    localparam logic [6:0] OP_LAST  = 7'(OP_WORDS - 1);

    logic [2:0]   state;
    logic [2:0]   state_nxt;
    logic [6:0]   cnt;
    logic [6:0]   cnt_nxt;
    logic         seq_begin_nxt;
    logic         job_done_nxt;
    logic         seq_begin_r;
    logic         job_done_r;
    logic [127:0] out_data_r;

    logic         accept;
    logic         w_write;
    logic         act_write;
    logic         in_load;
    logic         in_drain;
    logic         out_fire;
    logic         run_timeout;

    // ------------------------------------------------------------------
    // Decoded handshakes
    // ------------------------------------------------------------------
    assign in_load   = (state == S_LOAD_W) || (state == S_LOAD_ACT);
    assign in_drain  = (state == S_RD_REQ) || (state == S_RD_WAIT) ||
                       (state == S_RD_HOLD);
    assign accept    = in_valid && in_load;
    assign w_write   = accept && (state == S_LOAD_W);
    assign act_write = accept && (state == S_LOAD_ACT);
    assign out_fire  = (state == S_RD_HOLD) && out_ready;

`ifdef HOST_SEQ_TIMEOUT_EN
    logic [11:0] wd_cnt;

    // The watchdog counts consecutive RUN cycles; on the 4095th RUN cycle
    // without seq_done the job is abandoned.
    assign run_timeout = (state == S_RUN) && !seq_done && (wd_cnt == 12'd4094);

    // Watchdog counter restarts every time RUN is left so each job gets a
    // full window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= 12'd0;
        end else if (state == S_RUN) begin
            wd_cnt <= wd_cnt + 12'd1;
        end else begin
            wd_cnt <= 12'd0;
        end
    end

    // err is sticky: only reset clears a timeout indication.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (run_timeout) begin
            err <= 1'b1;
        end
    end
`else
    assign run_timeout = 1'b0;
    assign err         = 1'b0;
`endif

    // Next-state, counter and pulse decode for the job sequence.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        seq_begin_nxt = 1'b0;
        job_done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD_W;
                    cnt_nxt   = 7'd0;
                end
            end
            S_LOAD_W: begin
                if (accept) begin
                    if (cnt == W_LAST) begin
                        state_nxt = S_LOAD_ACT;
                        cnt_nxt   = 7'd0;
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end
            end
            S_LOAD_ACT: begin
                if (accept) begin
                    if (cnt == ACT_LAST) begin
                        state_nxt     = S_RUN;
                        cnt_nxt       = 7'd0;
                        seq_begin_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end
            end
            S_RUN: begin
                if (seq_done) begin
                    state_nxt = S_RD_REQ;
                    cnt_nxt   = 7'd0;
                end else if (run_timeout) begin
                    state_nxt    = S_IDLE;
                    cnt_nxt      = 7'd0;
                    job_done_nxt = 1'b1;
                end
            end
            S_RD_REQ: begin
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                state_nxt = S_RD_HOLD;
            end
            S_RD_HOLD: begin
                if (out_fire) begin
                    if (cnt == OP_LAST) begin
                        state_nxt    = S_IDLE;
                        cnt_nxt      = 7'd0;
                        job_done_nxt = 1'b1;
                    end else begin
                        state_nxt = S_RD_REQ;
                        cnt_nxt   = cnt + 7'd1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 7'd0;
            end
        endcase
    end

    // State, word counter and the two registered one-cycle pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= 7'd0;
            seq_begin_r <= 1'b0;
            job_done_r  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            seq_begin_r <= seq_begin_nxt;
            job_done_r  <= job_done_nxt;
        end
    end

    // OP SRAM has one cycle of read latency, so the word requested in
    // RD_REQ is on OP_q during RD_WAIT and is held here until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_r <= 128'd0;
        end else if (state == S_RD_WAIT) begin
            out_data_r <= OP_q;
        end
    end

    // ------------------------------------------------------------------
    // Status and stream outputs
    // ------------------------------------------------------------------
    assign busy      = (state != S_IDLE);
    assign host_sel  = in_load || in_drain;
    assign in_ready  = in_load;
    assign seq_begin = seq_begin_r;
    assign job_done  = job_done_r;
    assign out_valid = (state == S_RD_HOLD);
    assign out_data  = out_data_r;

    // ------------------------------------------------------------------
    // SRAM ports: strobes are active-low and only pulse on an accepted
    // word; address and data are zero whenever the port is not in use.
    // ------------------------------------------------------------------
    assign W_cen    = ~w_write;
    assign W_wen    = ~w_write;
    assign W_addr   = (state == S_LOAD_W) ? cnt : 7'd0;
    assign W_d      = w_write ? in_data : 32'd0;

    assign ACT_cen  = ~act_write;
    assign ACT_wen  = ~act_write;
    assign ACT_addr = (state == S_LOAD_ACT) ? cnt : 7'd0;
    assign ACT_d    = act_write ? in_data : 32'd0;

    assign OP_cen   = ~(state == S_RD_REQ);
    assign OP_wen   = 1'b1;
    assign OP_addr  = in_drain ? cnt[3:0] : 4'd0;

endmodule
